// File: rtl/mux_ndff_sync.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mux_ndff_sync
// Purpose  : Multi-bit CDC receiver. Only the enable is synchronized, and it
//            drives a load/recirculate mux in front of the payload register.
// Revision : 1.0  initial release
// ============================================================================
module mux_ndff_sync #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2   // legal range 2..4
) (
    input  logic              clkb,
    input  logic              rstn,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] data_sync
);

    logic [SYNC_STAGES-1:0] en_s_q;
    logic [SYNC_STAGES-1:0] en_s_d;
    logic                   en_sync;
    logic [DATA_W-1:0]      data_sync_q;
    logic [DATA_W-1:0]      data_sync_d;

    // Stage 0 is the only flop allowed to see the asynchronous enable.
    assign en_s_d[0] = en;

    generate
        for (genvar k = 1; k < SYNC_STAGES; k++) begin : g_sync_stage
            assign en_s_d[k] = en_s_q[k-1];
        end
    endgenerate

    assign en_sync = en_s_q[SYNC_STAGES-1];

    // Recirculation keeps data_sync X-free whenever the enable is low.
    always_comb begin
        data_sync_d = data_sync_q;
        if (en_sync) begin
            data_sync_d = data;
        end
    end

    always_ff @(posedge clkb or negedge rstn) begin
        if (!rstn) begin
            en_s_q      <= '0;
            data_sync_q <= '0;
        end else begin
            en_s_q      <= en_s_d;
            data_sync_q <= data_sync_d;
        end
    end

    assign data_sync = data_sync_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_ndff_sync.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mux_ndff_sync
// Purpose  : Self-checking bench: vector table, hand sequences, random run.
// Revision : 1.0  initial release
// ============================================================================
module tb_mux_ndff_sync;

    localparam int DW = 8;
    localparam int SS = 2;

    logic          clkb;
    logic          rstn;
    logic          en;
    logic [DW-1:0] data;
    logic [DW-1:0] data_sync;

    int total = 0;
    int bad   = 0;

    mux_ndff_sync #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
        .clkb      (clkb),
        .rstn      (rstn),
        .en        (en),
        .data      (data),
        .data_sync (data_sync)
    );

    initial begin
        clkb = 1'b0;
        forever #1.5 clkb = ~clkb;
    end

    // Reference: a load happens at an edge when en was 1 at the edge SS
    // edges earlier; the history is a queue of sampled enable levels.
    logic [DW-1:0] m_data;
    logic          m_en_q[$];

    always @(posedge clkb or negedge rstn) begin
        if (!rstn) begin
            m_data <= '0;
            m_en_q.delete();
            for (int k = 0; k < SS; k++) m_en_q.push_back(1'b0);
        end else begin
            if (m_en_q.size() > 0 && m_en_q[0]) m_data <= data;
            if (m_en_q.size() > 0) void'(m_en_q.pop_front());
            m_en_q.push_back(en);
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          en;
        logic [DW-1:0] data;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[14];

    initial begin
        bit            seen;
        int            n;
        logic [DW-1:0] prev;

        // Each row is driven at a falling edge; exp is data_sync after the
        // following rising edge (load uses en from SS rows earlier).
        vecs[0]  = '{1'b1, 8'h55, 8'h00};
        vecs[1]  = '{1'b1, 8'h55, 8'h00};
        vecs[2]  = '{1'b1, 8'h55, 8'h55};
        vecs[3]  = '{1'b0, 8'h55, 8'h55};
        vecs[4]  = '{1'b0, 8'h55, 8'h55};
        vecs[5]  = '{1'b0, 8'hFF, 8'h55};
        vecs[6]  = '{1'b0, 8'hFF, 8'h55};
        vecs[7]  = '{1'b1, 8'hAC, 8'h55};
        vecs[8]  = '{1'b1, 8'hAC, 8'h55};
        vecs[9]  = '{1'b1, 8'h3C, 8'h3C};
        vecs[10] = '{1'b0, 8'h3C, 8'h3C};
        vecs[11] = '{1'b0, 8'h3C, 8'h3C};
        vecs[12] = '{1'b0, 8'h99, 8'h3C};
        vecs[13] = '{1'b0, 8'h99, 8'h3C};

        en   = 1'b0;
        data = '0;
        rstn = 1'b0;
        #0.5;
        check("reset_async", data_sync, '0);
        #0.5;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clkb);
            check("reset_idle", data_sync, '0);
        end

        foreach (vecs[i]) begin
            en   = vecs[i].en;
            data = vecs[i].data;
            @(negedge clkb);
            check($sformatf("vec%0d", i), data_sync, vecs[i].exp);
        end

        // One-period pulse: a miss is tolerated.
        data = 8'hFF; en = 1'b1;
        @(negedge clkb);
        en = 1'b0;
        seen = 0;
        for (int i = 0; i < SS + 2; i++) begin
            @(negedge clkb);
            if (data_sync == 8'hFF) seen = 1;
        end
        if (!seen) $display("warning: one-period pulse was not loaded");

        // Two-period pulse must load.
        for (int i = 0; i < 2; i++) @(negedge clkb);
        data = 8'h5A; en = 1'b1;
        @(negedge clkb);
        @(negedge clkb);
        en = 1'b0;
        seen = 0;
        for (int i = 0; i < SS + 2; i++) begin
            @(negedge clkb);
            if (data_sync == 8'h5A) seen = 1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL pulse2_load: got %h expected 5a", data_sync);
        end
        for (int i = 0; i < 2; i++) @(negedge clkb);
        check("pulse2_value", data_sync, 8'h5A);

        // Hold: data changes while en is low.
        data = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clkb);
            check("hold", data_sync, 8'h5A);
        end

        // Final transfer: exact latency of SS+1 edges.
        data = 8'hAC; en = 1'b1;
        for (int i = 0; i < SS; i++) begin
            @(negedge clkb);
            check("xfer_early", data_sync, 8'h5A);
        end
        @(negedge clkb);
        check("xfer_load", data_sync, 8'hAC);
        for (int i = 0; i < 4; i++) begin
            @(negedge clkb);
            check("xfer_stable", data_sync, 8'hAC);
        end

        // Reset mid-operation with en held high.
        #0.5 rstn = 1'b0;
        #0.2;
        check("midrst_async", data_sync, '0);
        #0.3 rstn = 1'b1;
        for (int i = 0; i < SS; i++) begin
            @(negedge clkb);
            check("midrst_wait", data_sync, '0);
        end
        @(negedge clkb);
        check("midrst_reload", data_sync, 8'hAC);

        // Random run against the reference model.
        n = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3, 0) == 0) en = ~en;
            data = DW'($urandom);
            if ($urandom_range(49, 0) == 0) begin
                #0.5 rstn = 1'b0;
                #0.2;
                check("rand_rst", data_sync, '0);
                #0.3 rstn = 1'b1;
            end
            @(negedge clkb);
            prev = m_data;
            check("rand", data_sync, prev);
            n++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
